// File: rtl/fifo_ctrl.sv
// FIFO pointer/status controller for a 2^ADDR_WIDTH-entry register file.
// Drives write enable and both addresses; reports occupancy and sticky errors.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ALMOST_C = {1'b0, {ADDR_WIDTH{1'b1}}};

  logic                push_ok;
  logic                pop_ok;
  logic [ADDR_WIDTH:0] count_nxt;

  assign push_ok = wr && !full;
  assign pop_ok  = rd && !empty;
  assign wr_en   = push_ok;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  // Flags are registered from the next count so they move on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr      <= '0;
      r_addr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (push_ok) w_addr <= w_addr + 1'b1;
      if (pop_ok)  r_addr <= r_addr + 1'b1;
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_C);
      empty       <= (count_nxt == '0);
      almost_full <= (count_nxt >= ALMOST_C);
      // A new error event outranks a clear in the same cycle.
      if (wr && full)      overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (rd && empty)     underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus random push/pop traffic,
// compared against a queue-based reference and a local register-file model.
module tb_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          clr_err = 1'b0;
  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  logic [7:0]    wdata = 8'h00;
  logic [7:0]    mem [DEPTH];

  int            n_checks = 0;
  int            n_err = 0;

  byte unsigned  q[$];
  int            nw = 0;
  int            nr = 0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr),
    .rd          (rd),
    .clr_err     (clr_err),
    .wr_en       (wr_en),
    .w_addr      (w_addr),
    .r_addr      (r_addr),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[w_addr] <= wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    nw = 0;
    nr = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state(input string where);
    chk({where, ".count"},  32'(count),       32'(q.size()));
    chk({where, ".full"},   32'(full),        32'(q.size() == DEPTH));
    chk({where, ".empty"},  32'(empty),       32'(q.size() == 0));
    chk({where, ".afull"},  32'(almost_full), 32'(q.size() >= DEPTH - 1));
    chk({where, ".w_addr"}, 32'(w_addr),      32'(nw % DEPTH));
    chk({where, ".r_addr"}, 32'(r_addr),      32'(nr % DEPTH));
    chk({where, ".ovf"},    32'(overflow),    32'(m_ovf));
    chk({where, ".unf"},    32'(underflow),   32'(m_unf));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input string where, input bit w, input bit r, input bit c,
                       input logic [7:0] d);
    bit m_full, m_empty, push_ok, pop_ok;
    wr = w; rd = r; clr_err = c; wdata = d;
    #1;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    push_ok = w && !m_full;
    pop_ok  = r && !m_empty;
    chk({where, ".wr_en"}, 32'(wr_en), 32'(push_ok));
    if (pop_ok) chk({where, ".rd_data"}, 32'(mem[r_addr]), 32'(q[0]));
    if (w && m_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && m_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    if (pop_ok) begin void'(q.pop_front()); nr++; end
    if (push_ok) begin q.push_back(d); nw++; end
    @(posedge clk);
    #1;
    check_state(where);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state("reset");
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Fill
    cycle("fill", 1, 0, 0, 8'h11);
    cycle("fill", 1, 0, 0, 8'h22);
    cycle("fill", 1, 0, 0, 8'h33);
    cycle("fill", 1, 0, 0, 8'h44);
    for (int i = 0; i < DEPTH; i++) chk("fill.mem", 32'(mem[i]), 32'(8'h11 * (i + 1)));

    // Overflow then drain
    cycle("ovf", 1, 0, 0, 8'h55);
    chk("ovf.mem0", 32'(mem[0]), 32'h11);
    repeat (4) cycle("drain", 0, 1, 0, 8'h00);

    // Underflow and clear
    cycle("unf", 0, 1, 0, 8'h00);
    cycle("clr", 0, 0, 1, 8'h00);

    // Preload two, then sustained push+pop with pointer wrap
    cycle("pre", 1, 0, 0, 8'hA0);
    cycle("pre", 1, 0, 0, 8'hA1);
    for (int i = 0; i < 6; i++) cycle("both", 1, 1, 0, 8'hB0 + 8'(i));
    repeat (2) cycle("drain2", 0, 1, 0, 8'h00);

    // Simultaneous on empty, then on full
    cycle("both_empty", 1, 1, 0, 8'hC0);
    repeat (3) cycle("fill2", 1, 0, 0, 8'hC1);
    cycle("both_full", 1, 1, 0, 8'hC5);
    cycle("clr2", 0, 0, 1, 8'h00);

    // Clear coinciding with a new error event: set wins
    cycle("fill3", 1, 0, 0, 8'hD0);
    cycle("clr_vs_set", 1, 0, 1, 8'hD1);

    // Async reset mid-fill
    do_reset();
    cycle("mid", 1, 0, 0, 8'hE0);
    cycle("mid", 1, 0, 0, 8'hE1);
    cycle("mid", 1, 0, 0, 8'hE2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state("post_rst");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller that turns the 4x8 register file into a first-in/first-out buffer. It sits directly upstream of the register file and drives its `wr_en`, `w_addr` and `r_addr` from producer/consumer push/pop requests. It reports occupancy, full/empty and sticky overflow/underflow errors. Data itself passes straight between the producer, the register file and the consumer; this block never touches the data bus.

## Interface
- `ADDR_WIDTH`, default 2: pointer width. Depth is DEPTH = 2^ADDR_WIDTH (4 by default).
- `clk` in, 1: sole clock. All state updates on the rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `wr` in, 1: push request from the producer. Write data is presented to the register file in the same cycle.
- `rd` in, 1: pop request from the consumer.
- `clr_err` in, 1: synchronous clear of `overflow` and `underflow`.
- `wr_en` out, 1: write enable to the register file.
- `w_addr` out, ADDR_WIDTH: write pointer, the next free slot.
- `r_addr` out, ADDR_WIDTH: read pointer, the oldest entry.
- `full` out, 1: DEPTH entries held.
- `empty` out, 1: zero entries held.
- `almost_full` out, 1: count ≥ DEPTH-1.
- `count` out, ADDR_WIDTH+1: occupancy, range 0..DEPTH.
- `overflow` out, 1: sticky; a push was rejected.
- `underflow` out, 1: sticky; a pop was rejected.

## Operation
- Accept rules:
  - A push is accepted iff `wr && !full`.
  - A pop is accepted iff `rd && !empty`.
  - `wr_en` = `wr && !full` (combinational). A rejected push never writes the register file.
- Pointers:
  - An accepted push increments `w_addr` modulo DEPTH.
  - An accepted pop increments `r_addr` modulo DEPTH.
  - Both wrap from DEPTH-1 to 0 with no gap.
- Count:
  - Push only: +1. Pop only: -1. Both accepted: unchanged. Neither: unchanged.
  - `count` never exceeds DEPTH and never goes below 0.
- Flags are derived from the next count and registered:
  - `full` = (count == DEPTH).
  - `empty` = (count == 0).
  - `almost_full` = (count ≥ DEPTH-1).
  - Each flag changes in the same edge as `count`.
- Simultaneous events:
  - Full with `wr` and `rd`: pop accepted, push rejected, `overflow` set. `count` becomes DEPTH-1.
  - Empty with `wr` and `rd`: push accepted, pop rejected, `underflow` set. `count` becomes 1.
  - Neither full nor empty with both: both accepted. Register-file write and read address differ, so there is no collision.
- Errors:
  - `overflow` sets on any cycle with `wr && full`.
  - `underflow` sets on any cycle with `rd && empty`.
  - Both flags hold until `clr_err`. If `clr_err` and a new error event occur in the same cycle, the set wins.
- Read data:
  - The register file reads asynchronously at `r_addr`, so the oldest entry is visible whenever `!empty`.
  - The consumer samples the data in the same cycle it asserts `rd`.

## Timing
- Reset (async assert, release synchronised externally): `w_addr`=0, `r_addr`=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0. `wr_en` = `wr` (not full).
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Register file contents are not cleared but are treated as invalid.
- Latency:
  - Push to data readable: 1 cycle (`empty` falls on the edge that writes).
  - Pop to next entry at `r_addr`: 1 cycle.
- No handshake stall: requests are single-cycle strobes and may be held high for back-to-back transfers. One transfer per direction per cycle.
- `wr_en` is the only combinational output. All others come straight from registers.

## Test plan
- Reset and idle: hold `rst_n`=0 for 10 cycles, then release → `empty`=1, `count`=0, both addresses 0, both error flags 0.
- Fill: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles →
  - `w_addr` steps 1, 2, 3, 0.
  - `almost_full` rises after the 3rd push; `full`=1 after the 4th.
  - Register file holds 0x11..0x44 at addresses 0..3.
- Overflow and drain:
  - With full, push 0x55 → `wr_en`=0, `overflow`=1, entry 0 is still 0x11.
  - Then pop 4 times → data reads 0x11, 0x22, 0x33, 0x44 in order; `empty`=1; `r_addr`=0.
- Underflow and clear:
  - Pop while empty → `underflow`=1, `r_addr` unchanged.
  - Assert `clr_err` one cycle → both error flags return to 0.
- Simultaneous and wrap-around:
  - Preload 2 entries, then run 6 cycles with `wr`=`rd`=1 → `count` stays 2, both pointers wrap past 3, data comes out in FIFO order.
  - Simultaneous push/pop while empty → `count`=1, `underflow`=1.
  - Simultaneous push/pop while full → `count`=3, `overflow`=1.
- Async reset mid-fill: drop `rst_n` between clock edges after 3 pushes → `count`=0, `empty`=1 and pointers 0 before the next edge.
